// File: rtl/usb_host_token_tx.sv
// Full-speed USB host token transmitter (SOF/IN/OUT/SETUP): SYNC, PID, 11-bit field, CRC5, stuffing, NRZI, EOP.
// Latency: tx_en_o rises the cycle after a request is accepted; each bit holds BIT_SAMPLES clocks.
// Backpressure: req_ready_o is high only while idle; requests presented mid-packet wait until the block is idle.
module usb_host_token_tx #(
   parameter int BIT_SAMPLES = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  pid_i,
   input  logic [6:0]  addr_i,
   input  logic [3:0]  endp_i,
   input  logic [10:0] frame_i,
   output logic        done_o,
   output logic        err_o,
   output logic        tx_en_o,
   output logic        dp_tx_o,
   output logic        dn_tx_o
);

   localparam int CW = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_SAMPLES - 1);

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_FIELD, S_CRC, S_EOP_SE0, S_EOP_J
   } state_t;

   state_t         state_q, state_n;
   logic [CW-1:0]  cnt_q, cnt_n;
   logic [3:0]     idx_q, idx_n;
   logic [2:0]     ones_q, ones_n;
   logic           level_q, level_n;   // current line level, 1 = J
   logic [4:0]     crc_q, crc_n;
   logic [3:0]     pid_q, pid_n;
   logic [10:0]    field_q, field_n;
   logic           done_q, done_n;
   logic           err_q, err_n;

   // Position after the current bit and the data value sent there
   state_t         adv_state;
   logic [3:0]     adv_idx;
   logic           adv_data;
   logic           fb;
   logic           legal;
   logic [7:0]     pid_byte;
   logic [4:0]     crc_tx;

   assign legal    = (pid_i == PID_OUT) || (pid_i == PID_IN) ||
                     (pid_i == PID_SOF) || (pid_i == PID_SETUP);
   assign pid_byte = {~pid_q, pid_q};
   // Complemented CRC reordered so index 0 is the first bit on the wire (register MSB)
   assign crc_tx   = {~crc_q[0], ~crc_q[1], ~crc_q[2], ~crc_q[3], ~crc_q[4]};

   // Next-state: packet sequencing, stuffing, NRZI level and CRC accumulation
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      idx_n     = idx_q;
      ones_n    = ones_q;
      level_n   = level_q;
      crc_n     = crc_q;
      pid_n     = pid_q;
      field_n   = field_q;
      done_n    = 1'b0;
      err_n     = 1'b0;
      adv_state = state_q;
      adv_idx   = idx_q + 4'd1;
      adv_data  = 1'b0;
      fb        = 1'b0;

      case (state_q)
         S_SYNC:    if (idx_q == 4'd7)  begin adv_state = S_PID;     adv_idx = 4'd0; end
         S_PID:     if (idx_q == 4'd7)  begin adv_state = S_FIELD;   adv_idx = 4'd0; end
         S_FIELD:   if (idx_q == 4'd10) begin adv_state = S_CRC;     adv_idx = 4'd0; end
         S_CRC:     if (idx_q == 4'd4)  begin adv_state = S_EOP_SE0; adv_idx = 4'd0; end
         S_EOP_SE0: if (idx_q == 4'd1)  begin adv_state = S_EOP_J;   adv_idx = 4'd0; end
         S_EOP_J:   begin adv_state = S_IDLE; adv_idx = 4'd0; end
         default:   adv_idx = 4'd0;
      endcase

      case (adv_state)
         S_SYNC:  adv_data = (adv_idx == 4'd7);
         S_PID:   adv_data = pid_byte[adv_idx[2:0]];
         S_FIELD: adv_data = field_q[adv_idx];
         S_CRC:   adv_data = crc_tx[adv_idx[2:0]];
         default: adv_data = 1'b0;
      endcase

      if (state_q == S_IDLE) begin
         cnt_n = '0;
         if (req_valid_i) begin
            if (legal) begin
               state_n = S_SYNC;
               idx_n   = 4'd0;
               ones_n  = 3'd0;
               level_n = ~level_q;       // first SYNC bit is a 0: J -> K
               crc_n   = 5'b11111;
               pid_n   = pid_i;
               field_n = (pid_i == PID_SOF) ? frame_i : {endp_i, addr_i};
            end else begin
               err_n = 1'b1;
            end
         end
      end else if (cnt_q != CNT_LAST) begin
         cnt_n = cnt_q + CW'(1);
      end else begin
         cnt_n = '0;
         if (ones_q == 3'd6) begin
            // Stuffed 0: line toggles, position does not advance
            level_n = ~level_q;
            ones_n  = 3'd0;
         end else begin
            state_n = adv_state;
            idx_n   = adv_idx;
            case (adv_state)
               S_SYNC, S_PID, S_FIELD, S_CRC: begin
                  level_n = adv_data ? level_q : ~level_q;
                  ones_n  = adv_data ? (ones_q + 3'd1) : 3'd0;
               end
               S_EOP_SE0: ones_n = 3'd0;
               S_EOP_J:   level_n = 1'b1;
               default: begin
                  level_n = 1'b1;
                  done_n  = 1'b1;
               end
            endcase
            if (adv_state == S_FIELD) begin
               fb    = crc_q[4] ^ adv_data;
               crc_n = {crc_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
            end
         end
      end
   end

   // State register with synchronous reset; reset drops any packet in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 4'd0;
         ones_q  <= 3'd0;
         level_q <= 1'b1;
         crc_q   <= 5'b11111;
         pid_q   <= 4'd0;
         field_q <= 11'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         ones_q  <= ones_n;
         level_q <= level_n;
         crc_q   <= crc_n;
         pid_q   <= pid_n;
         field_q <= field_n;
         done_q  <= done_n;
         err_q   <= err_n;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign tx_en_o     = (state_q != S_IDLE);
   assign dp_tx_o     = (state_q == S_EOP_SE0) ? 1'b0 : level_q;
   assign dn_tx_o     = (state_q == S_EOP_SE0) ? 1'b0 : ~level_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_usb_host_token_tx.sv
// Bench for usb_host_token_tx: three instances (BIT_SAMPLES 2/4/8) share stimulus.
// Line activity is traced every cycle and decoded (NRZI, unstuffing, bit widths, EOP).
// Expected words come from hand constants or a small token/CRC5 model.
module tb_usb_host_token_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [3:0]  pid = 4'd0;
   logic [6:0]  addr = 7'd0;
   logic [3:0]  endp = 4'd0;
   logic [10:0] frame = 11'd0;
   logic [2:0]  rdy_v, done_v, err_v, en_v, dp_v, dn_v;

   int total = 0;
   int bad = 0;

   localparam int TMAX = 8192;
   // trace bits: 6 valid, 5 ready, 4 err, 3 done, 2 en, 1 dp, 0 dn
   logic [6:0] tr [3][TMAX];
   int tcnt = 0;

   always #5 clk = ~clk;

   usb_host_token_tx #(.BIT_SAMPLES(2)) u_bs2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy_v[0]),
      .pid_i(pid), .addr_i(addr), .endp_i(endp), .frame_i(frame),
      .done_o(done_v[0]), .err_o(err_v[0]), .tx_en_o(en_v[0]), .dp_tx_o(dp_v[0]), .dn_tx_o(dn_v[0]));
   usb_host_token_tx #(.BIT_SAMPLES(4)) u_bs4 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy_v[1]),
      .pid_i(pid), .addr_i(addr), .endp_i(endp), .frame_i(frame),
      .done_o(done_v[1]), .err_o(err_v[1]), .tx_en_o(en_v[1]), .dp_tx_o(dp_v[1]), .dn_tx_o(dn_v[1]));
   usb_host_token_tx #(.BIT_SAMPLES(8)) u_bs8 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy_v[2]),
      .pid_i(pid), .addr_i(addr), .endp_i(endp), .frame_i(frame),
      .done_o(done_v[2]), .err_o(err_v[2]), .tx_en_o(en_v[2]), .dp_tx_o(dp_v[2]), .dn_tx_o(dn_v[2]));

   // Record every instance once per cycle, away from the active edge
   always @(negedge clk) begin
      if (tcnt < TMAX) begin
         for (int k = 0; k < 3; k++)
            tr[k][tcnt] <= {req_valid, rdy_v[k], err_v[k], done_v[k], en_v[k], dp_v[k], dn_v[k]};
         tcnt <= tcnt + 1;
      end
   end

   function automatic int bs_of(input int k);
      return 2 << k;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Token model: SYNC, PID byte, 11-bit field, complemented CRC5 sent MSB first
   function automatic logic [31:0] model_word(input logic [3:0] p, input logic [10:0] f);
      logic [31:0] w;
      logic [4:0]  c;
      c = 5'b11111;
      for (int i = 0; i < 11; i++) begin
         if (c[4] ^ f[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
         else             c = {c[3:0], 1'b0};
      end
      c = ~c;
      w = '0;
      w[7:0]   = 8'h80;
      w[15:8]  = {~p, p};
      w[26:16] = f;
      for (int j = 0; j < 5; j++) w[27 + j] = c[4 - j];
      return w;
   endfunction

   function automatic int stuff_model(input logic [31:0] w);
      int ones, n;
      ones = 0;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         ones = w[i] ? ones + 1 : 0;
         if (ones == 6) begin
            n++;
            ones = 0;
         end
      end
      return n;
   endfunction

   // Decode the first packet at or after index 'from' of instance k
   task automatic decode(input int k, input int from, output int s, output int e,
                         output logic [31:0] w, output int nst, output int badw);
      int bs, nb, n, ones;
      logic [1:0] lv, prev;
      logic d;
      bs = bs_of(k);
      s = -1; e = -1; w = '0; nst = 0; badw = 0;
      for (int i = from; i < tcnt; i++) begin
         if (tr[k][i][2]) begin
            s = i;
            break;
         end
      end
      if (s < 0) return;
      e = s;
      while (e < tcnt && tr[k][e][2]) e++;
      if ((e - s) % bs != 0) badw++;
      nb = (e - s) / bs;
      for (int b = 0; b < nb; b++) begin
         lv = tr[k][s + b * bs][1:0];
         for (int j = 1; j < bs; j++)
            if (tr[k][s + b * bs + j][1:0] != lv) badw++;
      end
      if (nb < 4) begin
         badw++;
         return;
      end
      if (tr[k][s + (nb - 3) * bs][1:0] != 2'b00 || tr[k][s + (nb - 2) * bs][1:0] != 2'b00 ||
          tr[k][s + (nb - 1) * bs][1:0] != 2'b10) badw++;
      prev = 2'b10;
      ones = 0;
      n = 0;
      for (int b = 0; b < nb - 3; b++) begin
         lv = tr[k][s + b * bs][1:0];
         if (lv != 2'b10 && lv != 2'b01) badw++;
         d = (lv == prev);
         prev = lv;
         if (ones == 6) begin
            if (d) badw++;
            nst++;
            ones = 0;
         end else begin
            if (n < 32) w[n] = d;
            n++;
            ones = d ? ones + 1 : 0;
         end
      end
      if (n != 32) badw++;
   endtask

   task automatic check_pkt(input int k, input int from, input logic [31:0] xw, input int xs,
                            input string tag, output int s, output int e);
      logic [31:0] w;
      int nst, badw, dcnt;
      string nm;
      nm = $sformatf("%s bs%0d", tag, bs_of(k));
      decode(k, from, s, e, w, nst, badw);
      chk({nm, " found"}, int'(s >= 0), 1);
      if (s >= 0) begin
         chk({nm, " word"}, int'(w), int'(xw));
         chk({nm, " stuff"}, nst, xs);
         chk({nm, " cycles"}, e - s, bs_of(k) * (35 + xs));
         chk({nm, " widths/eop"}, badw, 0);
         chk({nm, " accept->en"}, int'(tr[k][s - 1][6] & tr[k][s - 1][5]), 1);
         chk({nm, " done pulse"}, int'({tr[k][e][3], tr[k][e + 1][3], tr[k][e][5]}), 3'b101);
         dcnt = 0;
         for (int i = s; i < e; i++) dcnt += int'(tr[k][i][3]);
         chk({nm, " early done"}, dcnt, 0);
      end
   endtask

   task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] ep, input logic [10:0] f);
      pid = p; addr = a; endp = ep; frame = f;
      req_valid = 1'b1;
      cyc(1);
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic [10:0] frame;
      logic [31:0] word;
      int          stf;
   } vec_t;

   vec_t vt[5];

   initial begin
      int s, e, s2, e2, from, a, cnt;
      logic [31:0] w;

      vt[0] = '{4'b1101, 7'h00, 4'h0, 11'h000, 32'h10002D80, 0};   // SETUP 0/0
      vt[1] = '{4'b1001, 7'h7F, 4'hF, 11'h000, 32'h47FF6980, 1};   // IN 7F/F
      vt[2] = '{4'b0101, 7'h00, 4'h0, 11'h3A5, 32'h0, 0};          // SOF 0x3A5
      vt[3] = '{4'b0101, 7'h00, 4'h0, 11'h7FF, 32'h47FFA580, 2};   // SOF 0x7FF
      vt[4] = '{4'b0001, 7'h3A, 4'h5, 11'h000, 32'h0, 0};          // OUT 3A/5
      w = model_word(4'b0101, 11'h3A5);
      vt[2].word = w; vt[2].stf = stuff_model(w);
      w = model_word(4'b0001, {4'h5, 7'h3A});
      vt[4].word = w; vt[4].stf = stuff_model(w);

      // Reset values
      cyc(3);
      chk("in-reset en", int'(en_v), 0);
      chk("in-reset dp", int'(dp_v), 3'b111);
      rst = 1'b0;
      cyc(1);
      chk("reset ready", int'(rdy_v), 3'b111);
      chk("reset en", int'(en_v), 0);
      chk("reset dp/dn", int'({dp_v, dn_v}), 6'b111000);
      chk("reset done/err", int'({done_v, err_v}), 0);

      // Table-driven tokens across all bit widths
      for (int i = 0; i < 5; i++) begin
         from = tcnt;
         send(vt[i].pid, vt[i].addr, vt[i].endp, vt[i].frame);
         cyc(330);
         for (int k = 0; k < 3; k++)
            check_pkt(k, from, vt[i].word, vt[i].stf, $sformatf("vec%0d", i), s, e);
      end

      // Illegal PID: err pulse only
      from = tcnt;
      send(4'b0011, 7'h01, 4'h1, 11'h0);
      cyc(6);
      a = -1;
      for (int i = from; i < tcnt; i++)
         if (a < 0 && tr[1][i][6] && tr[1][i][5]) a = i;
      chk("err accept seen", int'(a >= 0), 1);
      if (a >= 0) begin
         chk("err pulse", int'({tr[1][a + 1][4], tr[1][a + 2][4]}), 2'b10);
         chk("err ready kept", int'(tr[1][a + 1][5]), 1);
      end
      cnt = 0;
      for (int i = from; i < tcnt; i++) cnt += int'(tr[1][i][2]);
      chk("err no tx_en", cnt, 0);

      // Reset during FIELD aborts the packet
      send(4'b0001, 7'h15, 4'h3, 11'h0);
      cyc(70);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("abort en", int'(en_v[1]), 0);
      chk("abort dp/dn", int'({dp_v[1], dn_v[1]}), 2'b10);
      chk("abort done", int'(done_v[1]), 0);
      from = tcnt;
      cyc(20);
      cnt = 0;
      for (int i = from; i < tcnt; i++) cnt += int'(tr[1][i][3]) + int'(tr[1][i][2]);
      chk("abort quiet", cnt, 0);
      from = tcnt;
      send(4'b0001, 7'h15, 4'h3, 11'h0);
      cyc(330);
      w = model_word(4'b0001, {4'h3, 7'h15});
      for (int k = 0; k < 3; k++)
         check_pkt(k, from, w, stuff_model(w), "post-abort OUT", s, e);

      // Back-to-back with req_valid held high
      from = tcnt;
      pid = 4'b1001; addr = 7'h7F; endp = 4'hF; frame = 11'h0;
      req_valid = 1'b1;
      cyc(300);
      req_valid = 1'b0;
      cyc(340);
      for (int k = 0; k < 3; k++) begin
         check_pkt(k, from, 32'h47FF6980, 1, "b2b first", s, e);
         if (e > 0) begin
            check_pkt(k, e, 32'h47FF6980, 1, "b2b second", s2, e2);
            chk($sformatf("b2b gap bs%0d", bs_of(k)), s2 - e, 1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usb_host_token_tx.md
Name: usb_host_token_tx

Overview:
- Host-side full-speed USB token packet transmitter: SOF, IN, OUT and SETUP tokens.
- Drives the D+/D- lines that feed the device receiver (dp_rx_i/dn_rx_i of the CDC device).
- Used in the team's host emulator and bench harness.
- Builds SYNC, PID, 11-bit field and CRC5, applies bit stuffing and NRZI, and ends each packet with EOP, at BIT_SAMPLES clocks per bit.

Parameters:
BIT_SAMPLES, 4, clk_i cycles per USB bit (clk_i = 12 MHz * BIT_SAMPLES); legal range 2..16

Ports:
clk_i  in  1  clock, 12 MHz*BIT_SAMPLES
rst_i  in  1  reset (synchronous, active-high)
req_valid_i  in  1  token request valid
req_ready_o  out  1  block can accept a request (high only in IDLE)
pid_i  in  4  PID[3:0]: OUT 4'b0001, IN 4'b1001, SOF 4'b0101, SETUP 4'b1101
addr_i  in  7  device address (IN/OUT/SETUP)
endp_i  in  4  endpoint (IN/OUT/SETUP)
frame_i  in  11  frame number (SOF only)
done_o  out  1  one-cycle pulse when EOP completes
err_o  out  1  one-cycle pulse when a request with an illegal pid_i is accepted
tx_en_o  out  1  output driver enable
dp_tx_o  out  1  D+ drive
dn_tx_o  out  1  D- drive

Behaviour:
Reset values:
- tx_en_o=0, dp_tx_o=1, dn_tx_o=0 (J), done_o=0, err_o=0, state=IDLE.
- req_ready_o=1 from the first cycle after rst_i deasserts.
- rst_i mid-packet aborts the packet: the next cycle shows the reset values, with no EOP and no done_o.

Request handshake:
- A request is accepted when req_valid_i & req_ready_o are both high.
- pid_i, addr_i, endp_i and frame_i are captured in that cycle.
- Illegal pid_i: err_o pulses the next cycle, there is no bus activity, and the block stays in IDLE.

Packet timing:
- Legal pid_i: tx_en_o rises the cycle after acceptance.
- Each bit holds for exactly BIT_SAMPLES cycles, timed by a bit-sample counter 0..BIT_SAMPLES-1.

FSM: IDLE -> SYNC -> PID -> FIELD -> CRC -> EOP_SE0 -> EOP_J -> IDLE
- SYNC: 8 bits 0000_0001, LSB first; line sequence KJKJKJKK.
- PID: {~pid, pid}, LSB first.
- FIELD: 11 bits, LSB first. Tokens send {endp_i, addr_i} (addr bit0 first). SOF sends frame_i.
- CRC: CRC5, polynomial x^5+x^2+1, register init 5'b11111, updated over the 11 field bits only. Transmitted as the one's complement of the register, MSB (bit 4) first.
- EOP_SE0: 2 bit times with dp=0, dn=0.
- EOP_J: 1 bit time with dp=1, dn=0. Then tx_en_o=0, done_o pulses for one cycle, and the block returns to IDLE. req_ready_o is high the following cycle.

NRZI:
- The line level starts at J.
- Data 0 toggles J<->K; data 1 holds the level.
- J = (dp=1, dn=0); K = (dp=0, dn=1).

Bit stuffing:
- A ones counter counts consecutive data 1s, starting with the final SYNC bit (count=1 entering PID).
- After six consecutive 1s, a 0 is inserted and the counter clears.
- A stuff bit is still inserted when the sixth 1 is the last CRC bit, before the EOP.
- Stuff bits do not advance the field or CRC bit index.

Packet length:
- Total bit times = 35 + number of stuff bits; total cycles = BIT_SAMPLES * that.
- The maximum number of stuff bits for a token is 3.

Other rules:
- req_valid_i during a packet is ignored; it is neither accepted nor lost, and is accepted on return to IDLE.
- Inputs change only at acceptance; the captured values are used for the whole packet.

Test Plan:
- SETUP, addr 0, endp 0, BIT_SAMPLES=4 -> a bench NRZI/unstuff decoder yields bytes 0x80 (SYNC), 0x2D, 0x00, 0x10. Then SE0 for 8 cycles, J for 4 cycles, done_o pulses once. 140 cycles from the tx_en_o rise to its fall.
- IN, addr 0x7F, endp 0xF -> a stuff 0 is inserted after the 6th field bit. Decoded PID 0x69. The field decodes to all ones. CRC5 matches the bench model. Packet length equals 35 + stuff count bit times.
- SOF, frame 0x3A5, looped into the CDC device receiver -> the device frame_o reads 11'h3A5 after EOP. A second SOF with frame 0x7FF -> frame_o reads 11'h7FF.
- pid_i=4'b0011 with req_valid_i=1 -> err_o pulses one cycle, tx_en_o stays 0, req_ready_o stays 1.
- rst_i asserted for 1 cycle during the FIELD state -> the next cycle has tx_en_o=0, dp=1, dn=0, no done_o. A new OUT token afterwards transmits correctly.
- Back-to-back requests with req_valid_i held high -> the second packet's tx_en_o rises 2 cycles after the first EOP_J ends (1 IDLE accept cycle). Repeat with BIT_SAMPLES=2 and BIT_SAMPLES=8: bit widths scale exactly.
